// File: rtl/mux_scan_pkg.sv
// Shared state encoding and default widths for the mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned DEF_N_CH    = 4;
  localparam int unsigned DEF_SEL_W   = 2;
  localparam int unsigned DEF_DWELL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module mux_scan_dwell_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps the mux select, settles, samples y_in and publishes a snapshot.
// Optional MUX_SCAN_CONT_EN adds cont_in for back-to-back scans.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned N_CH    = DEF_N_CH,
  parameter int unsigned SEL_W   = DEF_SEL_W,
  parameter int unsigned DWELL_W = DEF_DWELL_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [DWELL_W-1:0] dwell_in,
  input  logic               y_in,
`ifdef MUX_SCAN_CONT_EN
  input  logic               cont_in,
`endif
  output logic [SEL_W-1:0]   sel_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [N_CH-1:0]    sample_out
);

  state_e               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 busy_q;
  logic                 done_q;
  logic [N_CH-1:0]      sample_q;
  logic [N_CH-1:0]      shadow_q;
  logic [N_CH-1:0]      shadow_d;
  logic [DWELL_W-1:0]   dwell_q;
  logic                 cnt_zero;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic [DWELL_W-1:0]   cnt_val;
  logic                 last_ch;
  logic                 cont_go;

`ifdef MUX_SCAN_CONT_EN
  assign cont_go = cont_in;
`else
  assign cont_go = 1'b0;
`endif

  assign last_ch = (sel_q == SEL_W'(N_CH - 1));

  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[sel_q] = y_in;
  end

  // Counter loads the live dwell only when leaving IDLE; every later reload uses the latched copy.
  assign cnt_load = ((state_q == ST_IDLE) && start_in)
                 || ((state_q == ST_SETTLE) && cnt_zero && !last_ch)
                 || ((state_q == ST_DONE) && cont_go);
  assign cnt_val  = (state_q == ST_IDLE) ? dwell_in : dwell_q;
  assign cnt_dec  = (state_q == ST_SETTLE) && !cnt_zero;

  mux_scan_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= '0;
      shadow_q <= '0;
      dwell_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            state_q <= ST_SETTLE;
            sel_q   <= '0;
            dwell_q <= dwell_in;
            busy_q  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            shadow_q <= shadow_d;
            if (last_ch) begin
              state_q  <= ST_DONE;
              sample_q <= shadow_d;
              done_q   <= 1'b1;
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          sel_q <= '0;
          if (cont_go) begin
            state_q <= ST_SETTLE;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_out    = sel_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign sample_out = sample_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with an inline 4:1 mux model on the feedback path.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dwell = '0;
  logic [3:0] d_vec = 4'b1010;
  logic       y;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] sample;
`ifdef MUX_SCAN_CONT_EN
  logic       cont = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  assign y = d_vec[sel];

  mux_scan_ctrl #(.N_CH(4), .SEL_W(2), .DWELL_W(4)) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .start_in   (start),
    .dwell_in   (dwell),
    .y_in       (y),
`ifdef MUX_SCAN_CONT_EN
    .cont_in    (cont),
`endif
    .sel_out    (sel),
    .busy_out   (busy),
    .done_out   (done),
    .sample_out (sample)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k counts edges after the one that samples start; scan is L = 4*(dwell+1) edges long.
  task automatic run_scan(input int unsigned dw, input int repulse_at, input int dchange_at,
                          input logic [3:0] exp_sample);
    int unsigned L;
    int unsigned exp_sel;
    L = 4 * (dw + 1);
    dwell = 4'(dw);
    start = 1'b1;
    tick();
    for (int k = 0; k <= int'(L) + 2; k++) begin
      if (k > 0) tick();
      if (k == 0)           exp_sel = 0;
      else if (k < int'(L)) exp_sel = 32'(k) / (dw + 1);
      else if (k == int'(L)) exp_sel = 3;
      else                  exp_sel = 0;
      check($sformatf("sel k=%0d", k), 32'(sel), exp_sel);
      check($sformatf("busy k=%0d", k), 32'(busy), 32'(k <= int'(L)));
      check($sformatf("done k=%0d", k), 32'(done), 32'(k == int'(L)));
      if (k >= int'(L)) check($sformatf("sample k=%0d", k), 32'(sample), 32'(exp_sample));
      start = (k == repulse_at);
      if (k == 0) dwell = ~4'(dw);
      if (k == dchange_at) d_vec = 4'b0101;
    end
    start = 1'b0;
  endtask

  initial begin
    #1;
    check("rst sel", 32'(sel), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst sample", 32'(sample), 0);
    tick();
    rst = 1'b0;
    tick();

    run_scan(0, -1, -1, 4'b1010);
    tick();
    run_scan(3, 4, -1, 4'b1010);
    tick();
    run_scan(1, 8, -1, 4'b1010);
    tick();

    dwell = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    check("pre-rst sel", 32'(sel), 2);
    rst = 1'b1;
    #1;
    check("mid-rst sel", 32'(sel), 0);
    check("mid-rst busy", 32'(busy), 0);
    check("mid-rst done", 32'(done), 0);
    check("mid-rst sample", 32'(sample), 0);
    tick();
    rst = 1'b0;
    tick();
    run_scan(0, -1, -1, 4'b1010);
    tick();

    run_scan(3, -1, 5, 4'b0100);
    d_vec = 4'b1010;
    tick();

`ifdef MUX_SCAN_CONT_EN
    cont = 1'b1;
    dwell = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("cont done k=%0d", k), 32'(done), 32'((k == 4) || (k == 9)));
      check($sformatf("cont busy k=%0d", k), 32'(busy), 32'(k <= 9));
      if (k == 9) begin
        check("cont sample", 32'(sample), 32'(4'b1010));
        cont = 1'b0;
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
